// File: rtl/cpu_control_if.sv
// Memory bus and ALU control bundle between the accumulator CPU sequencer
// (master) and the memory/ALU datapath (slave).
interface cpu_control_if #(
  parameter int PC_W = 5
);
  logic [7:0]      d_bus;
  logic [PC_W-1:0] addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [7:0]      instruction;
  logic            ldAcc;
  logic            useAlu;
  logic            dbusSelect;
  logic            c;
  logic            z;

  modport master (
    input  d_bus, c, z,
    output addr, mem_rd, mem_wr, instruction, ldAcc, useAlu, dbusSelect
  );

  modport slave (
    output d_bus, c, z,
    input  addr, mem_rd, mem_wr, instruction, ldAcc, useAlu, dbusSelect
  );
endinterface

// File: rtl/cpu_control.sv
// Three-phase sequencer (FETCH, EXEC_A, EXEC_B) and instruction decoder for
// the 8-bit accumulator CPU; strobes and addr are decoded from state/instruction.
module cpu_control #(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  cpu_control_if.master   bus,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC_A = 2'd2,
    EXEC_B = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_NAND  = 3'd2;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_LD    = 3'd4;
  localparam logic [2:0] OP_ST    = 3'd5;
  localparam logic [2:0] OP_JMP   = 3'd6;
  localparam logic [2:0] OP_JCZ   = 3'd7;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;

  logic [2:0]      opcode;
  logic [PC_W-1:0] operand;
  logic [PC_W-1:0] jcz_target;
  logic            jcz_flag;

  logic [PC_W-1:0] addr_s;
  logic            mem_rd_s, mem_wr_s, ld_acc_s, use_alu_s, dbus_sel_s, halted_s;

  assign opcode     = instr_q[7:5];
  assign operand    = PC_W'(instr_q[4:0]);
  assign jcz_target = PC_W'({1'b0, instr_q[3:0]});
  assign jcz_flag   = instr_q[4] ? bus.c : bus.z;

  // Next-state, program counter and instruction register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        // An X on run falls into the else branch and holds IDLE.
        if (run) state_d = FETCH;
        else     state_d = IDLE;
      end
      FETCH: begin
        instr_d = bus.d_bus;
        pc_d    = pc_q + PC_W'(1);
        state_d = EXEC_A;
      end
      EXEC_A: begin
        case (opcode)
          OP_ST:  state_d = EXEC_B;
          OP_JMP: begin
            pc_d    = operand;
            state_d = FETCH;
          end
          OP_JCZ: begin
            if (jcz_flag) pc_d = jcz_target;
            else          pc_d = pc_q;
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      EXEC_B:  state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state; reset aborts the current instruction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Strobe and address decode.
  always_comb begin
    addr_s     = pc_q;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    ld_acc_s   = 1'b0;
    use_alu_s  = 1'b0;
    dbus_sel_s = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      IDLE:  halted_s = 1'b1;
      FETCH: mem_rd_s = 1'b1;
      EXEC_A: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_NAND: begin
            addr_s    = operand;
            mem_rd_s  = 1'b1;
            use_alu_s = 1'b1;
          end
          OP_SHIFT: use_alu_s = 1'b1;
          OP_LD: begin
            addr_s   = operand;
            mem_rd_s = 1'b1;
            ld_acc_s = 1'b1;
          end
          default: addr_s = pc_q;
        endcase
      end
      EXEC_B: begin
        addr_s     = operand;
        dbus_sel_s = 1'b1;
        mem_wr_s   = 1'b1;
      end
      default: halted_s = 1'b1;
    endcase
  end

  assign bus.addr        = addr_s;
  assign bus.mem_rd      = mem_rd_s;
  assign bus.mem_wr      = mem_wr_s;
  assign bus.ldAcc       = ld_acc_s;
  assign bus.useAlu      = use_alu_s;
  assign bus.dbusSelect  = dbus_sel_s;
  assign bus.instruction = instr_q;
  assign pc              = pc_q;
  assign halted          = halted_s;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: a read-only program memory drives d_bus and
// a scoreboard of per-cycle expected outputs is popped at each falling edge.
module tb_cpu_control;
  localparam int PC_W = 5;

  // Packed observation: {halted, rd, wr, ldAcc, useAlu, dbusSel, addr, pc, instr}
  localparam logic [23:0] MASK_ALL    = 24'hFFFFFF;
  localparam logic [23:0] MASK_NOADDR = 24'hFC1FFF;

  localparam logic [5:0] S_IDLE  = 6'b100000;
  localparam logic [5:0] S_RD    = 6'b010000;
  localparam logic [5:0] S_LD    = 6'b010100;
  localparam logic [5:0] S_ALU   = 6'b010010;
  localparam logic [5:0] S_SHIFT = 6'b000010;
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_WR    = 6'b001001;

  typedef struct {
    string       tag;
    logic [23:0] exp;
    logic [23:0] mask;
  } sb_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [7:0]      mem [0:31];
  sb_t             sb_q[$];
  int              vectors = 0;
  int              miscompares = 0;

  cpu_control_if #(.PC_W(PC_W)) bus ();

  cpu_control #(.PC_W(PC_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  assign bus.d_bus = mem[bus.addr];

  task automatic push(input string tag, input logic [5:0] strb, input logic [4:0] a,
                      input logic [4:0] p, input logic [7:0] ins, input bit addr_care);
    sb_t e;
    e.tag  = tag;
    e.exp  = {strb, a, p, ins};
    e.mask = addr_care ? MASK_ALL : MASK_NOADDR;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    sb_t         e;
    logic [23:0] obs;
    obs = {halted, bus.mem_rd, bus.mem_wr, bus.ldAcc, bus.useAlu, bus.dbusSelect,
           bus.addr, pc, bus.instruction};
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h (mask %h)", e.tag, obs, e.exp, e.mask);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_now();
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    bus.c = 1'b0;
    bus.z = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'h85;  // LD 5
    mem[1]  = 8'hAA;  // ST 10
    mem[2]  = 8'h23;  // SUB 3
    mem[3]  = 8'h60;  // SHIFT
    mem[4]  = 8'hC7;  // JMP 7
    mem[7]  = 8'hE9;  // JZ 9
    mem[9]  = 8'hF4;  // JC 4
    mem[10] = 8'hDF;  // JMP 31
    mem[31] = 8'h60;  // SHIFT, pc wraps

    #2;
    push("reset_state", S_IDLE, 5'd0, 5'd0, 8'h00, 1'b1); check_now();
    @(negedge clk);
    reset = 1'b1;
    push("idle_run0", S_IDLE, 5'd0, 5'd0, 8'h00, 1'b1); step();
    run = 1'bx;
    push("idle_runx", S_IDLE, 5'd0, 5'd0, 8'h00, 1'b1); step();
    run = 1'b1;
    push("ld_fetch", S_RD, 5'd0, 5'd0, 8'h00, 1'b1); step();
    run = 1'b0;
    push("ld_exec_a", S_LD, 5'd5, 5'd1, 8'h85, 1'b1); step();
    push("st_fetch", S_RD, 5'd1, 5'd1, 8'h85, 1'b1); step();
    push("st_exec_a", S_NONE, 5'd0, 5'd2, 8'hAA, 1'b0); step();
    push("st_exec_b", S_WR, 5'd10, 5'd2, 8'hAA, 1'b1); step();
    push("sub_fetch", S_RD, 5'd2, 5'd2, 8'hAA, 1'b1); step();
    push("sub_exec_a", S_ALU, 5'd3, 5'd3, 8'h23, 1'b1); step();
    push("shift_fetch", S_RD, 5'd3, 5'd3, 8'h23, 1'b1); step();
    push("shift_exec_a", S_SHIFT, 5'd4, 5'd4, 8'h60, 1'b1); step();
    push("jmp_fetch", S_RD, 5'd4, 5'd4, 8'h60, 1'b1); step();
    push("jmp_exec_a", S_NONE, 5'd0, 5'd5, 8'hC7, 1'b0); step();
    push("jz_fetch", S_RD, 5'd7, 5'd7, 8'hC7, 1'b1); step();
    bus.z = 1'b1;
    bus.c = 1'b0;
    push("jz_exec_a", S_NONE, 5'd0, 5'd8, 8'hE9, 1'b0); step();
    push("jc_fetch", S_RD, 5'd9, 5'd9, 8'hE9, 1'b1); step();
    push("jc_exec_a", S_NONE, 5'd0, 5'd10, 8'hF4, 1'b0); step();
    push("jc_not_taken", S_RD, 5'd10, 5'd10, 8'hF4, 1'b1); step();
    bus.z = 1'b0;
    push("jmp31_exec_a", S_NONE, 5'd0, 5'd11, 8'hDF, 1'b0); step();
    push("wrap_fetch", S_RD, 5'd31, 5'd31, 8'hDF, 1'b1); step();
    push("wrap_exec_a", S_SHIFT, 5'd0, 5'd0, 8'h60, 1'b1); step();
    push("wrap_next_fetch", S_RD, 5'd0, 5'd0, 8'h60, 1'b1); step();
    push("ld2_exec_a", S_LD, 5'd5, 5'd1, 8'h85, 1'b1); step();
    push("st2_fetch", S_RD, 5'd1, 5'd1, 8'h85, 1'b1); step();
    push("st2_exec_a", S_NONE, 5'd0, 5'd2, 8'hAA, 1'b0); step();
    push("st2_exec_b", S_WR, 5'd10, 5'd2, 8'hAA, 1'b1); step();

    // Abort the store mid-EXEC_B: outputs must clear without a clock edge.
    reset = 1'b0;
    #1;
    push("async_abort", S_IDLE, 5'd0, 5'd0, 8'h00, 1'b1); check_now();
    run = 1'b1;
    push("held_in_reset", S_IDLE, 5'd0, 5'd0, 8'h00, 1'b1); step();
    reset = 1'b1;
    push("restart_fetch", S_RD, 5'd0, 5'd0, 8'h00, 1'b1); step();
    push("restart_ld", S_LD, 5'd5, 5'd1, 8'h85, 1'b1); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
